// File: rtl/v_mem_port_arbiter.sv
// Shares one axim_ctrl AXI master between NUM_REQ vector-core memory requesters.
// Read and write channels each run an independent round-robin grant FSM.

module v_mem_port_arb_chan #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int XFER_W  = 32,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*XFER_W-1:0] i_req_size,
    input  logic                      i_ctrl_done,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_req_done,
    output logic                      o_ctrl_start,
    output logic [ADDR_W-1:0]         o_ctrl_addr,
    output logic [XFER_W-1:0]         o_ctrl_size,
    output logic                      o_busy,
    output logic                      o_xfer,
    output logic [IDX_W-1:0]          o_grant
);

    typedef enum logic [1:0] {IDLE, START, XFER, FLUSH} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_grant;
    logic [IDX_W-1:0]    r_ptr;
    logic                r_start;
    logic [NUM_REQ-1:0]  r_ready;
    logic [NUM_REQ-1:0]  r_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [XFER_W-1:0]   r_size;

    logic                w_anyValid;
    logic                w_hiValid;
    logic [IDX_W-1:0]    w_lowAny;
    logic [IDX_W-1:0]    w_lowHi;
    logic [IDX_W-1:0]    w_pick;
    logic [ADDR_W-1:0]   w_pickAddr;
    logic [XFER_W-1:0]   w_pickSize;
    logic [NUM_REQ-1:0]  w_pickOnehot;
    logic [NUM_REQ-1:0]  w_grantOnehot;
    logic [IDX_W-1:0]    w_ptrNext;

    // Round-robin: lowest valid index at or above r_ptr, else wrap to the lowest valid overall
    always_comb begin
        w_anyValid = 1'b0;
        w_hiValid  = 1'b0;
        w_lowAny   = '0;
        w_lowHi    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                w_anyValid = 1'b1;
                w_lowAny   = IDX_W'(i);
                if (i >= int'(r_ptr)) begin
                    w_hiValid = 1'b1;
                    w_lowHi   = IDX_W'(i);
                end
            end
        end
        w_pick = w_hiValid ? w_lowHi : w_lowAny;
    end

    assign w_pickAddr    = i_req_addr[w_pick*ADDR_W +: ADDR_W];
    assign w_pickSize    = i_req_size[w_pick*XFER_W +: XFER_W];
    assign w_pickOnehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
    assign w_grantOnehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
    assign w_ptrNext     = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_start <= 1'b0;
            r_ready <= '0;
            r_done  <= '0;
            r_addr  <= '0;
            r_size  <= '0;
        end else begin
            r_start <= 1'b0;
            r_ready <= '0;
            r_done  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_anyValid) begin
                        r_grant <= w_pick;
                        r_addr  <= w_pickAddr;
                        r_size  <= w_pickSize;
                        r_ready <= w_pickOnehot;
                        // A zero-byte request is acknowledged without touching the AXI master
                        if (w_pickSize == '0) begin
                            r_state <= FLUSH;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= START;
                        end
                    end
                end
                START: r_state <= XFER;
                XFER: begin
                    if (i_ctrl_done) begin
                        r_done  <= w_grantOnehot;
                        r_ptr   <= w_ptrNext;
                        r_state <= IDLE;
                    end
                end
                FLUSH: begin
                    r_done  <= w_grantOnehot;
                    r_ptr   <= w_ptrNext;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready  = r_ready;
    assign o_req_done   = r_done;
    assign o_ctrl_start = r_start;
    assign o_ctrl_addr  = r_addr;
    assign o_ctrl_size  = r_size;
    assign o_busy       = (r_state != IDLE);
    assign o_xfer       = (r_state == XFER);
    assign o_grant      = r_grant;

endmodule

module v_mem_port_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [NUM_REQ-1:0]                    i_rreq_valid,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] i_rreq_addr,
    input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0]  i_rreq_size,
    output logic [NUM_REQ-1:0]                    o_rreq_ready,
    output logic [NUM_REQ-1:0]                    o_rreq_done,
    output logic [NUM_REQ-1:0]                    o_rdata_tvalid,
    input  logic [NUM_REQ-1:0]                    i_rdata_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]         o_rdata_tdata,
    output logic                                  o_rdata_tlast,
    input  logic [NUM_REQ-1:0]                    i_wreq_valid,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] i_wreq_addr,
    input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0]  i_wreq_size,
    output logic [NUM_REQ-1:0]                    o_wreq_ready,
    output logic [NUM_REQ-1:0]                    o_wreq_done,
    input  logic [NUM_REQ-1:0]                    i_wdata_tvalid,
    input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0] i_wdata_tdata,
    output logic [NUM_REQ-1:0]                    o_wdata_tready,
    output logic                                  o_ctrl_rstart,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         o_ctrl_raddr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]          o_ctrl_rxfer_size,
    input  logic                                  i_ctrl_rdone,
    input  logic                                  i_rd_tvalid,
    input  logic                                  i_rd_tlast,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]         i_rd_tdata,
    output logic                                  o_rd_tready,
    output logic                                  o_ctrl_wstart,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         o_ctrl_waddr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]          o_ctrl_wxfer_size,
    input  logic                                  i_ctrl_wdone,
    input  logic                                  i_wr_tready,
    output logic                                  o_wr_tvalid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]         o_wr_tdata,
    output logic                                  o_rd_busy,
    output logic                                  o_wr_busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int DATA_W = C_M_AXI_DATA_WIDTH;

    logic               w_rXfer;
    logic               w_wXfer;
    logic [IDX_W-1:0]   w_rGrant;
    logic [IDX_W-1:0]   w_wGrant;
    logic [NUM_REQ-1:0] w_rGrantOnehot;
    logic [NUM_REQ-1:0] w_wGrantOnehot;

    v_mem_port_arb_chan #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (C_M_AXI_ADDR_WIDTH),
        .XFER_W  (C_XFER_SIZE_WIDTH),
        .IDX_W   (IDX_W)
    ) u_rd_chan (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_rreq_valid),
        .i_req_addr   (i_rreq_addr),
        .i_req_size   (i_rreq_size),
        .i_ctrl_done  (i_ctrl_rdone),
        .o_req_ready  (o_rreq_ready),
        .o_req_done   (o_rreq_done),
        .o_ctrl_start (o_ctrl_rstart),
        .o_ctrl_addr  (o_ctrl_raddr_offset),
        .o_ctrl_size  (o_ctrl_rxfer_size),
        .o_busy       (o_rd_busy),
        .o_xfer       (w_rXfer),
        .o_grant      (w_rGrant)
    );

    v_mem_port_arb_chan #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (C_M_AXI_ADDR_WIDTH),
        .XFER_W  (C_XFER_SIZE_WIDTH),
        .IDX_W   (IDX_W)
    ) u_wr_chan (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_wreq_valid),
        .i_req_addr   (i_wreq_addr),
        .i_req_size   (i_wreq_size),
        .i_ctrl_done  (i_ctrl_wdone),
        .o_req_ready  (o_wreq_ready),
        .o_req_done   (o_wreq_done),
        .o_ctrl_start (o_ctrl_wstart),
        .o_ctrl_addr  (o_ctrl_waddr_offset),
        .o_ctrl_size  (o_ctrl_wxfer_size),
        .o_busy       (o_wr_busy),
        .o_xfer       (w_wXfer),
        .o_grant      (w_wGrant)
    );

    assign w_rGrantOnehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_rGrant;
    assign w_wGrantOnehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_wGrant;

    // Stream steering is purely combinational so beats see no added latency
    assign o_rd_tready    = w_rXfer & i_rdata_tready[w_rGrant];
    assign o_rdata_tvalid = (w_rXfer & i_rd_tvalid) ? w_rGrantOnehot : '0;
    assign o_rdata_tdata  = i_rd_tdata;
    assign o_rdata_tlast  = i_rd_tlast;

    assign o_wr_tvalid    = w_wXfer & i_wdata_tvalid[w_wGrant];
    assign o_wr_tdata     = w_wXfer ? i_wdata_tdata[w_wGrant*DATA_W +: DATA_W] : '0;
    assign o_wdata_tready = (w_wXfer & i_wr_tready) ? w_wGrantOnehot : '0;

endmodule

// File: tb/tb_v_mem_port_arbiter.sv
// Scenario bench for v_mem_port_arbiter: the bench plays both the requesters and axim_ctrl,
// queueing expected grants and beats as stimulus is driven and popping them as outputs appear.

module tb_v_mem_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int XW = 32;

    typedef struct {
        int          req;
        logic [DW-1:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]    rreqValid, rreqReady, rreqDone, rdataTvalid, rdataTready;
    logic [NR*AW-1:0] rreqAddr, wreqAddr;
    logic [NR*XW-1:0] rreqSize, wreqSize;
    logic [DW-1:0]    rdataTdata, rdTdata, wrTdata;
    logic             rdataTlast, rdTvalid, rdTlast, rdTready, ctrlRdone, ctrlRstart;
    logic [NR-1:0]    wreqValid, wreqReady, wreqDone, wdataTvalid, wdataTready;
    logic [NR*DW-1:0] wdataTdata;
    logic             ctrlWstart, ctrlWdone, wrTready, wrTvalid, rdBusy, wrBusy;
    logic [AW-1:0]    ctrlRaddr, ctrlWaddr;
    logic [XW-1:0]    ctrlRsize, ctrlWsize;

    beat_t beatQ[$];
    int    grantQ[$];
    int    nChecks = 0;
    int    nFails  = 0;

    v_mem_port_arbiter #(
        .NUM_REQ(NR), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_XFER_SIZE_WIDTH(XW)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rreq_valid(rreqValid), .i_rreq_addr(rreqAddr), .i_rreq_size(rreqSize),
        .o_rreq_ready(rreqReady), .o_rreq_done(rreqDone),
        .o_rdata_tvalid(rdataTvalid), .i_rdata_tready(rdataTready),
        .o_rdata_tdata(rdataTdata), .o_rdata_tlast(rdataTlast),
        .i_wreq_valid(wreqValid), .i_wreq_addr(wreqAddr), .i_wreq_size(wreqSize),
        .o_wreq_ready(wreqReady), .o_wreq_done(wreqDone),
        .i_wdata_tvalid(wdataTvalid), .i_wdata_tdata(wdataTdata), .o_wdata_tready(wdataTready),
        .o_ctrl_rstart(ctrlRstart), .o_ctrl_raddr_offset(ctrlRaddr), .o_ctrl_rxfer_size(ctrlRsize),
        .i_ctrl_rdone(ctrlRdone), .i_rd_tvalid(rdTvalid), .i_rd_tlast(rdTlast),
        .i_rd_tdata(rdTdata), .o_rd_tready(rdTready),
        .o_ctrl_wstart(ctrlWstart), .o_ctrl_waddr_offset(ctrlWaddr), .o_ctrl_wxfer_size(ctrlWsize),
        .i_ctrl_wdone(ctrlWdone), .i_wr_tready(wrTready), .o_wr_tvalid(wrTvalid),
        .o_wr_tdata(wrTdata), .o_rd_busy(rdBusy), .o_wr_busy(wrBusy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        rreqValid = '0; rreqAddr = '0; rreqSize = '0; rdataTready = '0;
        wreqValid = '0; wreqAddr = '0; wreqSize = '0; wdataTvalid = '0; wdataTdata = '0;
        ctrlRdone = 1'b0; rdTvalid = 1'b0; rdTlast = 1'b0; rdTdata = '0;
        ctrlWdone = 1'b0; wrTready = 1'b0;
    endtask

    task automatic pulseReset();
        clearInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Cycles until ctrl_rstart is seen, or -1 if it never shows within the budget
    task automatic waitRstart(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ctrlRstart === 1'b1) begin
                cyc = n;
                break;
            end
        end
    endtask

    function automatic int onehotIdx(input logic [NR-1:0] v);
        int idx = -1;
        for (int i = 0; i < NR; i++) if (v[i] === 1'b1) idx = i;
        return idx;
    endfunction

    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        nChecks++;
        if ({rreqReady, rreqDone, wreqReady, wreqDone} !== '0) begin
            nFails++; $display("[TB] FAIL reset_handshake: got %h expected 0", {rreqReady, rreqDone, wreqReady, wreqDone});
        end
        nChecks++;
        if ({ctrlRstart, ctrlWstart, rdBusy, wrBusy, rdTready, wrTvalid} !== '0) begin
            nFails++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {ctrlRstart, ctrlWstart, rdBusy, wrBusy, rdTready, wrTvalid});
        end
        nChecks++;
        if ({ctrlRaddr, ctrlRsize, ctrlWaddr, ctrlWsize, wrTdata} !== '0) begin
            nFails++; $display("[TB] FAIL reset_cmd: got %h expected 0", {ctrlRaddr, ctrlRsize, ctrlWaddr, ctrlWsize, wrTdata});
        end
        nChecks++;
        if ({rdataTvalid, wdataTready} !== '0) begin
            nFails++; $display("[TB] FAIL reset_stream: got %b expected 0", {rdataTvalid, wdataTready});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        int    cyc;
        beat_t exp;
        beat_t b;
        pulseReset();
        rreqValid = 4'b0100;
        rreqAddr[2*AW +: AW] = 32'h1000;
        rreqSize[2*XW +: XW] = 32'd64;
        waitRstart(cyc);
        nChecks++;
        if (cyc !== 1) begin nFails++; $display("[TB] FAIL single_start_latency: got %0d expected 1", cyc); end
        nChecks++;
        if (ctrlRaddr !== 32'h1000 || ctrlRsize !== 32'd64) begin
            nFails++; $display("[TB] FAIL single_cmd: got %h/%0d expected 1000/64", ctrlRaddr, ctrlRsize);
        end
        nChecks++;
        if (rreqReady !== 4'b0100) begin nFails++; $display("[TB] FAIL single_ready: got %b expected 0100", rreqReady); end
        rreqValid = '0;
        tick();
        for (int k = 0; k < 16; k++) begin
            rdTvalid = 1'b1;
            rdTdata = 32'hA000 + k;
            rdTlast = (k == 15);
            rdataTready = '1;
            b.req = 2; b.data = rdTdata; b.last = rdTlast;
            beatQ.push_back(b);
            #1;
            nChecks++;
            if (rdataTvalid !== 4'b0100) begin nFails++; $display("[TB] FAIL single_tvalid: got %b expected 0100", rdataTvalid); end
            if (rdataTvalid[2] === 1'b1 && beatQ.size() > 0) begin
                exp = beatQ.pop_front();
                nChecks++;
                if (rdataTdata !== exp.data || rdataTlast !== exp.last) begin
                    nFails++; $display("[TB] FAIL single_beat: got %h/%b expected %h/%b", rdataTdata, rdataTlast, exp.data, exp.last);
                end
            end
            tick();
        end
        rdTvalid = 1'b0; rdTlast = 1'b0;
        ctrlRdone = 1'b1;
        nChecks++;
        if (rreqDone !== '0) begin nFails++; $display("[TB] FAIL single_done_early: got %b expected 0000", rreqDone); end
        tick();
        ctrlRdone = 1'b0;
        nChecks++;
        if (rreqDone !== 4'b0100 || rdBusy !== 1'b0) begin
            nFails++; $display("[TB] FAIL single_done: got %b busy %b expected 0100 busy 0", rreqDone, rdBusy);
        end
        tick();
        nChecks++;
        if (rreqDone !== '0 || beatQ.size() != 0) begin
            nFails++; $display("[TB] FAIL single_done_pulse: got %b left %0d expected 0000 left 0", rreqDone, beatQ.size());
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        int got;
        int expG;
        pulseReset();
        for (int i = 0; i < NR; i++) begin
            rreqAddr[i*AW +: AW] = 32'h100 * (i + 1);
            rreqSize[i*XW +: XW] = 32'd8;
        end
        rreqValid = '1;
        rdataTready = '1;
        grantQ = '{0, 1, 2, 3, 0};
        for (int t = 0; t < 5; t++) begin
            waitRstart(cyc);
            // After the first grant, one cycle was already spent on the done pulse
            if (t > 0 && cyc > 0) cyc = cyc + 1;
            nChecks++;
            if (cyc !== ((t == 0) ? 1 : 2)) begin
                nFails++; $display("[TB] FAIL rr_start_gap: transfer %0d got %0d expected %0d", t, cyc, (t == 0) ? 1 : 2);
            end
            got = onehotIdx(rreqReady);
            expG = grantQ.pop_front();
            nChecks++;
            if (got !== expG || ctrlRaddr !== 32'h100 * (expG + 1)) begin
                nFails++; $display("[TB] FAIL rr_grant: got %0d addr %h expected %0d", got, ctrlRaddr, expG);
            end
            tick();
            rdTvalid = 1'b1;
            rdTdata = DW'(t);
            #1;
            nChecks++;
            if (rdataTvalid !== (4'b0001 << expG)) begin
                nFails++; $display("[TB] FAIL rr_route: got %b expected grant %0d", rdataTvalid, expG);
            end
            tick();
            rdTvalid = 1'b0;
            ctrlRdone = 1'b1;
            tick();
            ctrlRdone = 1'b0;
            if (t == 4) rreqValid = '0;
            nChecks++;
            if (rreqDone !== (4'b0001 << expG)) begin
                nFails++; $display("[TB] FAIL rr_done: got %b expected grant %0d", rreqDone, expG);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int          cyc;
        logic [3:0]  pat = 4'b0101;
        logic        p;
        beat_t       b;
        beat_t       exp;
        pulseReset();
        rreqValid = 4'b0010;
        rreqAddr[1*AW +: AW] = 32'h2400;
        rreqSize[1*XW +: XW] = 32'd16;
        waitRstart(cyc);
        nChecks++;
        if (cyc !== 1 || rreqReady !== 4'b0010) begin
            nFails++; $display("[TB] FAIL bp_grant: got %0d/%b expected 1/0010", cyc, rreqReady);
        end
        rreqValid = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            p = pat[k];
            rdataTready = {~p, ~p, p, ~p};
            rdTvalid = 1'b1;
            rdTdata = 32'hB0 + k;
            if (p) begin b.req = 1; b.data = rdTdata; b.last = 1'b0; beatQ.push_back(b); end
            #1;
            nChecks++;
            if (rdTready !== p) begin nFails++; $display("[TB] FAIL bp_tready: beat %0d got %b expected %b", k, rdTready, p); end
            nChecks++;
            if (rdataTvalid !== 4'b0010) begin nFails++; $display("[TB] FAIL bp_tvalid: beat %0d got %b expected 0010", k, rdataTvalid); end
            if (rdataTvalid[1] === 1'b1 && rdataTready[1] === 1'b1 && beatQ.size() > 0) begin
                exp = beatQ.pop_front();
                nChecks++;
                if (rdataTdata !== exp.data) begin nFails++; $display("[TB] FAIL bp_data: got %h expected %h", rdataTdata, exp.data); end
            end
            tick();
        end
        rdTvalid = 1'b0;
        ctrlRdone = 1'b1;
        tick();
        ctrlRdone = 1'b0;
        nChecks++;
        if (rreqDone !== 4'b0010 || beatQ.size() != 0) begin
            nFails++; $display("[TB] FAIL bp_done: got %b left %0d expected 0010 left 0", rreqDone, beatQ.size());
        end
    endtask

    task automatic test_concurrent();
        int    cyc;
        beat_t b;
        beat_t exp;
        pulseReset();
        rreqValid = 4'b0001;
        rreqAddr[0 +: AW] = 32'h2000;
        rreqSize[0 +: XW] = 32'd16;
        wreqValid = 4'b1000;
        wreqAddr[3*AW +: AW] = 32'h3000;
        wreqSize[3*XW +: XW] = 32'd16;
        waitRstart(cyc);
        nChecks++;
        if (cyc !== 1 || ctrlWstart !== 1'b1) begin
            nFails++; $display("[TB] FAIL conc_starts: got %0d wstart %b expected 1 wstart 1", cyc, ctrlWstart);
        end
        nChecks++;
        if (wreqReady !== 4'b1000 || rreqReady !== 4'b0001 || ctrlWaddr !== 32'h3000) begin
            nFails++; $display("[TB] FAIL conc_ready: got %b/%b/%h expected 1000/0001/3000", wreqReady, rreqReady, ctrlWaddr);
        end
        rreqValid = '0; wreqValid = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            wdataTvalid = '1;
            for (int i = 0; i < NR; i++) wdataTdata[i*DW +: DW] = DW'(((i + 1) << 8) | k);
            wrTready = 1'b1;
            rdTvalid = 1'b1;
            rdTdata = DW'(k);
            rdataTready = '1;
            b.req = 3; b.data = DW'((4 << 8) | k); b.last = 1'b0;
            beatQ.push_back(b);
            #1;
            nChecks++;
            if (wrTvalid !== 1'b1 || wdataTready !== 4'b1000 || rdataTvalid !== 4'b0001) begin
                nFails++; $display("[TB] FAIL conc_route: got %b/%b/%b expected 1/1000/0001", wrTvalid, wdataTready, rdataTvalid);
            end
            if (wrTvalid === 1'b1 && beatQ.size() > 0) begin
                exp = beatQ.pop_front();
                nChecks++;
                if (wrTdata !== exp.data) begin nFails++; $display("[TB] FAIL conc_wdata: got %h expected %h", wrTdata, exp.data); end
            end
            tick();
        end
        wdataTvalid = '0; wrTready = 1'b0; rdTvalid = 1'b0;
        ctrlWdone = 1'b1;
        tick();
        ctrlWdone = 1'b0;
        nChecks++;
        if (wreqDone !== 4'b1000 || rreqDone !== '0 || rdBusy !== 1'b1 || wrBusy !== 1'b0) begin
            nFails++; $display("[TB] FAIL conc_wdone: got %b/%b busy %b%b expected 1000/0000 busy 10", wreqDone, rreqDone, rdBusy, wrBusy);
        end
        ctrlRdone = 1'b1;
        tick();
        ctrlRdone = 1'b0;
        nChecks++;
        if (rreqDone !== 4'b0001 || wreqDone !== '0) begin
            nFails++; $display("[TB] FAIL conc_rdone: got %b/%b expected 0001/0000", rreqDone, wreqDone);
        end
    endtask

    task automatic test_zero_size();
        logic startSeen = 1'b0;
        pulseReset();
        wreqValid = 4'b0010;
        wreqAddr[1*AW +: AW] = 32'h5000;
        wreqSize[1*XW +: XW] = '0;
        tick();
        startSeen = startSeen | ctrlWstart;
        nChecks++;
        if (wreqReady !== 4'b0010 || wrBusy !== 1'b1) begin
            nFails++; $display("[TB] FAIL zero_ready: got %b busy %b expected 0010 busy 1", wreqReady, wrBusy);
        end
        wreqValid = '0;
        tick();
        startSeen = startSeen | ctrlWstart;
        nChecks++;
        if (wreqDone !== 4'b0010 || wreqReady !== '0 || wrBusy !== 1'b0) begin
            nFails++; $display("[TB] FAIL zero_done: got %b/%b busy %b expected 0010/0000 busy 0", wreqDone, wreqReady, wrBusy);
        end
        tick();
        startSeen = startSeen | ctrlWstart;
        nChecks++;
        if (wreqDone !== '0 || startSeen !== 1'b0) begin
            nFails++; $display("[TB] FAIL zero_nostart: got done %b start %b expected 0000 start 0", wreqDone, startSeen);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        pulseReset();
        rreqValid = 4'b0100;
        rreqAddr[2*AW +: AW] = 32'h4000;
        rreqSize[2*XW +: XW] = 32'd16;
        rreqAddr[3*AW +: AW] = 32'h4800;
        rreqSize[3*XW +: XW] = 32'd16;
        // Complete one transfer from requester 2 so the pointer moves off zero first
        waitRstart(cyc);
        rreqValid = '0;
        tick();
        ctrlRdone = 1'b1;
        tick();
        ctrlRdone = 1'b0;
        rreqValid = 4'b0100;
        waitRstart(cyc);
        nChecks++;
        if (cyc !== 1 || rreqReady !== 4'b0100) begin
            nFails++; $display("[TB] FAIL rstmid_grant: got %0d/%b expected 1/0100", cyc, rreqReady);
        end
        rreqValid = '0;
        tick();
        rdTvalid = 1'b1;
        rdataTready = '1;
        #1;
        nChecks++;
        if (rdataTvalid !== 4'b0100) begin nFails++; $display("[TB] FAIL rstmid_xfer: got %b expected 0100", rdataTvalid); end
        rst = 1'b1;
        ctrlRdone = 1'b1;
        tick();
        nChecks++;
        if ({rreqDone, rreqReady, rdataTvalid} !== '0 || {rdBusy, rdTready, ctrlRstart} !== '0 ||
            {ctrlRaddr, ctrlRsize} !== '0) begin
            nFails++; $display("[TB] FAIL rstmid_outputs: got %b%b%b busy %b tready %b cmd %h expected all 0",
                               rreqDone, rreqReady, rdataTvalid, rdBusy, rdTready, {ctrlRaddr, ctrlRsize});
        end
        rst = 1'b0; ctrlRdone = 1'b0; rdTvalid = 1'b0;
        tick();
        nChecks++;
        if (rreqDone !== '0) begin nFails++; $display("[TB] FAIL rstmid_nodone: got %b expected 0000", rreqDone); end
        rreqValid = 4'b1100;
        waitRstart(cyc);
        nChecks++;
        if (cyc !== 1 || rreqReady !== 4'b0100) begin
            nFails++; $display("[TB] FAIL rstmid_regrant: got %0d/%b expected 1/0100", cyc, rreqReady);
        end
        rreqValid = '0;
        tick();
        ctrlRdone = 1'b1;
        tick();
        ctrlRdone = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_backpressure();
        test_concurrent();
        test_zero_size();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/v_mem_port_arbiter.md
Name: v_mem_port_arbiter

Overview:
- Shares the single `axim_ctrl` AXI master between `NUM_REQ` vector-core memory requesters, such as load/store units and the scalar-core bridge.
- Read and write channels have independent round-robin arbiters.
- Each arbiter latches one granted request, issues the `ctrl_rstart`/`ctrl_wstart` command, and steers the data stream to or from the winner.
- It holds the grant until `ctrl_rdone`/`ctrl_wdone`, then rotates priority.

Parameters:
- `NUM_REQ`, 4, number of requesters per channel (2..8).
- `C_M_AXI_ADDR_WIDTH`, 32, address width.
- `C_M_AXI_DATA_WIDTH`, 32, stream data width.
- `C_XFER_SIZE_WIDTH`, 32, transfer size width in bytes.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `rreq_valid`  in  NUM_REQ  read request per requester
- `rreq_addr`  in  NUM_REQ*ADDR_W  packed read byte address, requester i at slice i
- `rreq_size`  in  NUM_REQ*XFER_W  packed read byte count
- `rreq_ready`  out  NUM_REQ  request accepted (1-cycle pulse)
- `rreq_done`  out  NUM_REQ  read transfer complete (1-cycle pulse)
- `rdata_tvalid`  out  NUM_REQ  read beat valid, granted requester only
- `rdata_tready`  in  NUM_REQ  requester read backpressure
- `rdata_tdata`  out  DATA_W  read beat, broadcast to all requesters
- `rdata_tlast`  out  1  last read beat
- `wreq_valid`, `wreq_addr`, `wreq_size`, `wreq_ready`, `wreq_done`  same widths and meanings as the read set, for writes
- `wdata_tvalid`  in  NUM_REQ  write beat valid
- `wdata_tdata`  in  NUM_REQ*DATA_W  packed write beats
- `wdata_tready`  out  NUM_REQ  write beat accepted, granted requester only
- `ctrl_rstart`  out  1  to `axim_ctrl`
- `ctrl_raddr_offset`  out  ADDR_W  to `axim_ctrl`
- `ctrl_rxfer_size`  out  XFER_W  to `axim_ctrl`
- `ctrl_rdone`  in  1  from `axim_ctrl`
- `rd_tvalid`  in  1  from `axim_ctrl`
- `rd_tlast`  in  1  from `axim_ctrl`
- `rd_tdata`  in  DATA_W  from `axim_ctrl`
- `rd_tready`  out  1  to `axim_ctrl`
- `ctrl_wstart`  out  1  to `axim_ctrl`
- `ctrl_waddr_offset`  out  ADDR_W  to `axim_ctrl`
- `ctrl_wxfer_size`  out  XFER_W  to `axim_ctrl`
- `ctrl_wdone`  in  1  from `axim_ctrl`
- `wr_tready`  in  1  from `axim_ctrl`
- `wr_tvalid`  out  1  to `axim_ctrl`
- `wr_tdata`  out  DATA_W  to `axim_ctrl`
- `rd_busy`, `wr_busy`  out  1  channel state != IDLE

Behaviour:
- The read and write channels are identical and fully independent. The read channel is described below; the write channel mirrors it.
- **Reset:** `rst` sampled high forces state=IDLE, grant=0, rr_ptr=0, and all outputs to 0, including the latched `ctrl_*addr`/`ctrl_*size`.
  - Reset mid-transfer aborts with no done pulse; `rst` also drives `axim_ctrl` reset.
- **FSM states:** IDLE, START, XFER, FLUSH.
- **IDLE:** if `rreq_valid` != 0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register the grant index g, `ctrl_raddr_offset` <= addr[g], `ctrl_rxfer_size` <= size[g].
  - Next state is START, or FLUSH if size[g]==0.
- **START (1 cycle):**
  - `ctrl_rstart`=1 and `rreq_ready[g]`=1.
  - Next state is XFER.
  - Requesters hold valid/addr/size stable until their ready pulse.
- **XFER:**
  - `rd_tready` = `rdata_tready[g]`.
  - `rdata_tvalid[i]` = `rd_tvalid` & (i==g); `rdata_tdata`/`rdata_tlast` pass through combinationally, with zero added latency.
  - When `ctrl_rdone`=1: `rreq_done[g]` pulses in the next cycle, state returns to IDLE in that same next cycle, and rr_ptr <= (g+1) mod NUM_REQ.
- **FLUSH (size 0):**
  - `rreq_ready[g]`=1 and no `ctrl_rstart`.
  - Next cycle: `rreq_done[g]`=1, rr_ptr <= g+1, state IDLE.
- **Latency:**
  - valid at cycle 0 (IDLE) -> `ctrl_rstart` at cycle 1.
  - `ctrl_rdone` at cycle N -> done at N+1 -> next `ctrl_rstart` at N+2 at the earliest.
- **Outside XFER:**
  - `rd_tready`=0 and all `rdata_tvalid`=0.
  - `ctrl_rdone` is ignored outside XFER.
- **Stable command:** `ctrl_raddr_offset`/`ctrl_rxfer_size` stay constant from START until return to IDLE.
- **Write channel specifics:**
  - `wr_tvalid` = `wdata_tvalid[g]` and `wr_tdata` = `wdata_tdata` slice g in XFER, else 0.
  - `wdata_tready[i]` = `wr_tready` & XFER & (i==g).
- **Collisions:** simultaneous read and write grants are legal, with no cross-channel interaction. The same requester may hold a read grant and a write grant at once.
- **Fairness:** a continuously asserted request is granted within NUM_REQ transfers.

Test Plan:
- **Single read:** `rreq_valid`=4'b0100, addr=0x1000, size=64.
  - Expect `ctrl_rstart` 1 cycle later with offset 0x1000 and size 64, plus `rreq_ready[2]`.
  - 16 beats routed only to `rdata_tvalid[2]`; `rreq_done[2]` one cycle after `ctrl_rdone`.
- **Round-robin:** all 4 read requesters valid continuously from reset.
  - Grant order 0,1,2,3,0.
  - Each `ctrl_rstart` occurs exactly 2 cycles after the previous `ctrl_rdone`.
- **Backpressure:** granted requester 1 toggles `rdata_tready` 1,0,1,0.
  - `rd_tready` mirrors it exactly; no beat is seen by requesters 0, 2 or 3.
- **Concurrent read and write:** read req 0 and write req 3 valid in the same cycle.
  - `ctrl_rstart` and `ctrl_wstart` fire in the same cycle.
  - `wr_tdata` equals `wdata_tdata` slice 3 for all beats.
  - Dones are independent.
- **Zero size:** `wreq_valid[1]` with size=0.
  - `wreq_ready[1]` then `wreq_done[1]` on consecutive cycles, and no `ctrl_wstart`.
- **Reset mid-transfer:** assert `rst` during XFER with grant 2.
  - Next cycle all outputs are 0, `rd_busy`=0, and there is no `rreq_done`.
  - After release, requesters 2 and 3 both valid: requester 2 is granted first (rr_ptr=0).
